// File: rtl/e203_exu_oitf.sv
// Outstanding instruction track FIFO: records in-flight long-latency writes in
// dispatch order and flags operands of the dispatching instruction that hit one.
module e203_exu_oitf #(
   parameter int OITF_DEPTH = 2,
   parameter int ITAG_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  dis_ena,
   output logic                  dis_ready,
   output logic [ITAG_WIDTH-1:0] dis_ptr,

   input  logic                  ret_ena,
   output logic [ITAG_WIDTH-1:0] ret_ptr,
   output logic [4:0]            ret_rdidx,
   output logic                  ret_rdwen,
   output logic                  ret_rdfpu,
   output logic [31:0]           ret_pc,

   output logic                  oitf_empty,

   input  logic                  disp_i_rs1en,
   input  logic                  disp_i_rs2en,
   input  logic                  disp_i_rs3en,
   input  logic                  disp_i_rdwen,
   input  logic                  disp_i_rs1fpu,
   input  logic                  disp_i_rs2fpu,
   input  logic                  disp_i_rs3fpu,
   input  logic                  disp_i_rdfpu,
   input  logic [4:0]            disp_i_rs1idx,
   input  logic [4:0]            disp_i_rs2idx,
   input  logic [4:0]            disp_i_rs3idx,
   input  logic [4:0]            disp_i_rdidx,
   input  logic [31:0]           disp_i_pc,

   output logic                  oitfrd_match_disprs1,
   output logic                  oitfrd_match_disprs2,
   output logic                  oitfrd_match_disprs3,
   output logic                  oitfrd_match_disprd
);

   localparam logic [ITAG_WIDTH-1:0] LP_LAST_PTR = ITAG_WIDTH'(OITF_DEPTH - 1);

   logic [ITAG_WIDTH-1:0] r_alloc_ptr;
   logic                  r_alloc_flg;
   logic [ITAG_WIDTH-1:0] r_ret_ptr;
   logic                  r_ret_flg;

   logic                  r_vld   [OITF_DEPTH];
   logic [4:0]            r_rdidx [OITF_DEPTH];
   logic                  r_rdwen [OITF_DEPTH];
   logic                  r_rdfpu [OITF_DEPTH];
   logic [31:0]           r_pc    [OITF_DEPTH];

   logic w_full;
   logic w_alloc;
   logic w_ret;
   logic w_match_rs1;
   logic w_match_rs2;
   logic w_match_rs3;
   logic w_match_rd;

   // Same index with differing wrap flags means the writer has lapped the reader.
   assign oitf_empty = (r_alloc_ptr == r_ret_ptr) & (r_alloc_flg == r_ret_flg);
   assign w_full     = (r_alloc_ptr == r_ret_ptr) & (r_alloc_flg != r_ret_flg);
   assign dis_ready  = ~w_full;
   assign w_alloc    = dis_ena & ~w_full;
   assign w_ret      = ret_ena & ~oitf_empty;

   assign dis_ptr    = r_alloc_ptr;
   assign ret_ptr    = r_ret_ptr;
   assign ret_rdidx  = r_rdidx[r_ret_ptr];
   assign ret_rdwen  = r_rdwen[r_ret_ptr];
   assign ret_rdfpu  = r_rdfpu[r_ret_ptr];
   assign ret_pc     = r_pc[r_ret_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alloc_ptr <= '0;
         r_alloc_flg <= 1'b0;
         r_ret_ptr   <= '0;
         r_ret_flg   <= 1'b0;
      end else begin
         if (w_alloc) begin
            if (r_alloc_ptr == LP_LAST_PTR) begin
               r_alloc_ptr <= '0;
               r_alloc_flg <= ~r_alloc_flg;
            end else begin
               r_alloc_ptr <= r_alloc_ptr + 1'b1;
            end
         end
         if (w_ret) begin
            if (r_ret_ptr == LP_LAST_PTR) begin
               r_ret_ptr <= '0;
               r_ret_flg <= ~r_ret_flg;
            end else begin
               r_ret_ptr <= r_ret_ptr + 1'b1;
            end
         end
      end
   end

   // NOTE: the payload array is reset as well, not just the valid bits, so the
   // ret_* outputs read back as zero after reset instead of stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OITF_DEPTH; i++) begin
            r_vld[i]   <= 1'b0;
            r_rdidx[i] <= '0;
            r_rdwen[i] <= 1'b0;
            r_rdfpu[i] <= 1'b0;
            r_pc[i]    <= '0;
         end
      end else begin
         // Alloc and retire only share an index when full or empty, where one is blocked.
         for (int i = 0; i < OITF_DEPTH; i++) begin
            if (w_alloc && (r_alloc_ptr == ITAG_WIDTH'(i))) begin
               r_vld[i]   <= 1'b1;
               r_rdidx[i] <= disp_i_rdidx;
               r_rdwen[i] <= disp_i_rdwen;
               r_rdfpu[i] <= disp_i_rdfpu;
               r_pc[i]    <= disp_i_pc;
            end else if (w_ret && (r_ret_ptr == ITAG_WIDTH'(i))) begin
               r_vld[i]   <= 1'b0;
            end
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_match_rs1 = 1'b0;
      w_match_rs2 = 1'b0;
      w_match_rs3 = 1'b0;
      w_match_rd  = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         if (r_vld[i] && r_rdwen[i]) begin
            if (disp_i_rs1en && (r_rdidx[i] == disp_i_rs1idx) && (r_rdfpu[i] == disp_i_rs1fpu))
               w_match_rs1 = 1'b1;
            if (disp_i_rs2en && (r_rdidx[i] == disp_i_rs2idx) && (r_rdfpu[i] == disp_i_rs2fpu))
               w_match_rs2 = 1'b1;
            if (disp_i_rs3en && (r_rdidx[i] == disp_i_rs3idx) && (r_rdfpu[i] == disp_i_rs3fpu))
               w_match_rs3 = 1'b1;
            if (disp_i_rdwen && (r_rdidx[i] == disp_i_rdidx) && (r_rdfpu[i] == disp_i_rdfpu))
               w_match_rd = 1'b1;
         end
      end
   end

   assign oitfrd_match_disprs1 = w_match_rs1;
   assign oitfrd_match_disprs2 = w_match_rs2;
   assign oitfrd_match_disprs3 = w_match_rs3;
   assign oitfrd_match_disprd  = w_match_rd;

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Directed bench for e203_exu_oitf at depth 2: fill, full/empty guards,
// simultaneous alloc+retire, RAW matching, pointer wrap and async reset.
module tb_e203_exu_oitf;

   logic        clk;
   logic        rst_n;
   logic        dis_ena;
   logic        dis_ready;
   logic [0:0]  dis_ptr;
   logic        ret_ena;
   logic [0:0]  ret_ptr;
   logic [4:0]  ret_rdidx;
   logic        ret_rdwen;
   logic        ret_rdfpu;
   logic [31:0] ret_pc;
   logic        oitf_empty;
   logic        disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
   logic        disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu;
   logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
   logic [31:0] disp_i_pc;
   logic        oitfrd_match_disprs1, oitfrd_match_disprs2;
   logic        oitfrd_match_disprs3, oitfrd_match_disprd;

   int checks = 0;
   int errors = 0;

   e203_exu_oitf #(.OITF_DEPTH(2), .ITAG_WIDTH(1)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .dis_ena              (dis_ena),
      .dis_ready            (dis_ready),
      .dis_ptr              (dis_ptr),
      .ret_ena              (ret_ena),
      .ret_ptr              (ret_ptr),
      .ret_rdidx            (ret_rdidx),
      .ret_rdwen            (ret_rdwen),
      .ret_rdfpu            (ret_rdfpu),
      .ret_pc               (ret_pc),
      .oitf_empty           (oitf_empty),
      .disp_i_rs1en         (disp_i_rs1en),
      .disp_i_rs2en         (disp_i_rs2en),
      .disp_i_rs3en         (disp_i_rs3en),
      .disp_i_rdwen         (disp_i_rdwen),
      .disp_i_rs1fpu        (disp_i_rs1fpu),
      .disp_i_rs2fpu        (disp_i_rs2fpu),
      .disp_i_rs3fpu        (disp_i_rs3fpu),
      .disp_i_rdfpu         (disp_i_rdfpu),
      .disp_i_rs1idx        (disp_i_rs1idx),
      .disp_i_rs2idx        (disp_i_rs2idx),
      .disp_i_rs3idx        (disp_i_rs3idx),
      .disp_i_rdidx         (disp_i_rdidx),
      .disp_i_pc            (disp_i_pc),
      .oitfrd_match_disprs1 (oitfrd_match_disprs1),
      .oitfrd_match_disprs2 (oitfrd_match_disprs2),
      .oitfrd_match_disprs3 (oitfrd_match_disprs3),
      .oitfrd_match_disprd  (oitfrd_match_disprd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs and checks then sit mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_disp();
      disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0; disp_i_rdwen = 0;
      disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0; disp_i_rdfpu = 0;
      disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rs3idx = 0; disp_i_rdidx = 0;
      disp_i_pc = 0;
   endtask

   task automatic set_alloc(input logic [4:0] rd, input logic wen, input logic [31:0] pc);
      disp_i_rdidx = rd;
      disp_i_rdwen = wen;
      disp_i_rdfpu = 1'b0;
      disp_i_pc    = pc;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, " empty"},   oitf_empty, 1);
      check({pfx, " ready"},   dis_ready, 1);
      check({pfx, " dis_ptr"}, dis_ptr, 0);
      check({pfx, " ret_ptr"}, ret_ptr, 0);
      check({pfx, " rdidx"},   ret_rdidx, 0);
      check({pfx, " rdwen"},   ret_rdwen, 0);
      check({pfx, " rdfpu"},   ret_rdfpu, 0);
      check({pfx, " pc"},      ret_pc, 0);
      check({pfx, " m_rs1"},   oitfrd_match_disprs1, 0);
      check({pfx, " m_rs2"},   oitfrd_match_disprs2, 0);
      check({pfx, " m_rs3"},   oitfrd_match_disprs3, 0);
      check({pfx, " m_rd"},    oitfrd_match_disprd, 0);
   endtask

   initial begin
      rst_n = 0; dis_ena = 0; ret_ena = 0;
      clear_disp();
      // Reset state with operands that would hit index 0 if anything were valid
      disp_i_rs1en = 1; disp_i_rs2en = 1; disp_i_rs3en = 1; disp_i_rdwen = 1;
      #12;
      check_reset_outputs("rst");
      rst_n = 1;
      clear_disp();

      // Fill: rd=5 pc=0x100, then rd=6 pc=0x104
      dis_ena = 1; set_alloc(5'd5, 1, 32'h100);
      #1 check("alloc0 dis_ptr pre", dis_ptr, 0);
      tick();
      check("alloc0 empty", oitf_empty, 0);
      check("alloc0 ready", dis_ready, 1);
      check("alloc0 dis_ptr", dis_ptr, 1);
      set_alloc(5'd6, 1, 32'h104);
      tick();
      dis_ena = 0; clear_disp();
      #1;
      check("fill ready", dis_ready, 0);
      check("fill empty", oitf_empty, 0);
      check("fill rdidx", ret_rdidx, 5);
      check("fill pc", ret_pc, 32'h100);
      check("fill rdwen", ret_rdwen, 1);
      check("fill dis_ptr", dis_ptr, 0);
      check("fill ret_ptr", ret_ptr, 0);

      // Matching against both pending writes
      disp_i_rs1en = 1; disp_i_rs1idx = 6;
      disp_i_rs2en = 0; disp_i_rs2idx = 5;
      disp_i_rs3en = 1; disp_i_rs3idx = 6; disp_i_rs3fpu = 1;
      disp_i_rdwen = 1; disp_i_rdidx = 5;
      #1;
      check("full m_rs1", oitfrd_match_disprs1, 1);
      check("full m_rs2 en0", oitfrd_match_disprs2, 0);
      check("full m_rs3 fpu", oitfrd_match_disprs3, 0);
      check("full m_rd", oitfrd_match_disprd, 1);
      clear_disp();

      // Spurious dis_ena while full
      dis_ena = 1; set_alloc(5'd9, 1, 32'h200);
      tick();
      dis_ena = 0; clear_disp();
      #1;
      check("full ign ready", dis_ready, 0);
      check("full ign dis_ptr", dis_ptr, 0);
      check("full ign ret_ptr", ret_ptr, 0);
      check("full ign rdidx", ret_rdidx, 5);

      // Full + retire + alloc in the same cycle: alloc blocked, retire taken
      dis_ena = 1; ret_ena = 1; set_alloc(5'd9, 1, 32'h200);
      #1 check("same cyc ready", dis_ready, 0);
      tick();
      dis_ena = 0; ret_ena = 0; clear_disp();
      #1;
      check("ret1 ret_ptr", ret_ptr, 1);
      check("ret1 ready", dis_ready, 1);
      check("ret1 empty", oitf_empty, 0);
      check("ret1 rdidx", ret_rdidx, 6);
      check("ret1 pc", ret_pc, 32'h104);
      check("ret1 dis_ptr", dis_ptr, 0);
      disp_i_rs1en = 1; disp_i_rs1idx = 5;
      disp_i_rs2en = 1; disp_i_rs2idx = 9;
      disp_i_rs3en = 1; disp_i_rs3idx = 6;
      #1;
      check("ret1 m_rs1 retired", oitfrd_match_disprs1, 0);
      check("ret1 m_rs2 blocked", oitfrd_match_disprs2, 0);
      check("ret1 m_rs3 pending", oitfrd_match_disprs3, 1);
      clear_disp();

      // Drain the last entry; both pointers wrap to 0
      ret_ena = 1;
      tick();
      ret_ena = 0;
      #1;
      check("drain empty", oitf_empty, 1);
      check("drain ret_ptr", ret_ptr, 0);
      check("drain dis_ptr", dis_ptr, 0);

      // Spurious ret_ena while empty
      ret_ena = 1;
      tick();
      ret_ena = 0;
      #1;
      check("empty ign empty", oitf_empty, 1);
      check("empty ign ret_ptr", ret_ptr, 0);
      check("empty ign dis_ptr", dis_ptr, 0);
      check("empty ign ready", dis_ready, 1);

      // RAW: entry rd=7 rdwen=1 rdfpu=0
      dis_ena = 1; set_alloc(5'd7, 1, 32'h300);
      tick();
      dis_ena = 0; clear_disp();
      disp_i_rs2en = 1; disp_i_rs2idx = 7; disp_i_rs2fpu = 0;
      #1 check("raw rs2 hit", oitfrd_match_disprs2, 1);
      disp_i_rs2fpu = 1;
      #1 check("raw rs2 fpu", oitfrd_match_disprs2, 0);
      disp_i_rs2fpu = 0; disp_i_rs2en = 0;
      #1 check("raw rs2 en0", oitfrd_match_disprs2, 0);
      clear_disp();
      // Zero latency against pre-edge state: retiring entry still matches this cycle
      ret_ena = 1; disp_i_rs1en = 1; disp_i_rs1idx = 7;
      #1 check("raw retiring hit", oitfrd_match_disprs1, 1);
      tick();
      ret_ena = 0;
      #1 check("raw retired miss", oitfrd_match_disprs1, 0);
      clear_disp();

      // Async reset with two entries pending
      dis_ena = 1; set_alloc(5'd8, 1, 32'h400);
      tick();
      set_alloc(5'd10, 1, 32'h404);
      tick();
      dis_ena = 0; clear_disp();
      disp_i_rs1en = 1; disp_i_rs1idx = 8;
      #1;
      check("pre-rst ready", dis_ready, 0);
      check("pre-rst m_rs1", oitfrd_match_disprs1, 1);
      rst_n = 0;
      #1;
      check_reset_outputs("async rst");
      tick();
      rst_n = 1;
      clear_disp();

      // Wrap: 5 alloc/retire pairs from reset; first entry has rdwen=0
      for (int p = 0; p < 5; p++) begin
         dis_ena = 1; set_alloc(5'd3, (p != 0), 32'h500 + 32'(4 * p));
         tick();
         dis_ena = 0; clear_disp();
         #1;
         check("wrap alloc empty", oitf_empty, 0);
         if (p == 0) begin
            disp_i_rdwen = 1; disp_i_rdidx = 3;
            #1 check("wrap rdwen0 m_rd", oitfrd_match_disprd, 0);
            clear_disp();
         end
         ret_ena = 1;
         tick();
         ret_ena = 0;
         #1 check("wrap pair empty", oitf_empty, 1);
      end
      check("wrap ret_ptr", ret_ptr, 1);
      check("wrap dis_ptr", dis_ptr, 1);
      check("wrap ready", dis_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
